serial_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 30 +++
 rtl/serial_rx_if.sv | 37 +++
 rtl/serial_baud_tick.sv | 42 ++++
 rtl/serial_rx.sv | 199 +++++++++++++++++++
 tb/tb_serial_rx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the RS-232 receive path (and later the transmit
// path): FSM state encoding, oversampling sample positions, frame width,
// and the three-sample majority vote.
// No ports.
package serial_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rxState_t;

  // Tick positions within a 16x oversampled bit
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] BIT_END    = 4'd15;

  localparam int DATA_BITS = 8;

  // Two-of-three vote used to reject single-sample noise
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_if.sv
// serial_rx_if
// Byte-level bundle between the serial receiver and its consumer.
// Signals:
//   rxd           serial line into the receiver (idle high)
//   rcv_data      last received byte, LSB = first bit on the line
//   rcv_valid     one-cycle strobe, rcv_data is new and good
//   rcv_frame_err one-cycle strobe, stop bit was sampled low
//   rcv_busy      receiver is inside a frame
// Modports:
//   master  receiver side (consumes rxd, produces the byte outputs)
//   slave   line driver / consumer side
interface serial_rx_if;
  import serial_pkg::*;

  logic                 rxd;
  logic [DATA_BITS-1:0] rcv_data;
  logic                 rcv_valid;
  logic                 rcv_frame_err;
  logic                 rcv_busy;

  modport master (
    input  rxd,
    output rcv_data,
    output rcv_valid,
    output rcv_frame_err,
    output rcv_busy
  );

  modport slave (
    output rxd,
    input  rcv_data,
    input  rcv_valid,
    input  rcv_frame_err,
    input  rcv_busy
  );

endinterface

// File: rtl/serial_baud_tick.sv
// serial_baud_tick
// Oversampling tick generator: a one-cycle pulse every
// CLK_FREQ/(BAUD*OVERSAMPLE) clocks (integer-truncated).
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   clear  restarts the period so the next tick is a full DIV clocks away
//   tick   one-cycle pulse
module serial_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  // Tick fires on the last count of the period, so after a clear the first
  // tick arrives exactly DIV clocks later.
  assign w_tick = (r_cnt == CNT_W'(DIV - 1));
  assign tick   = w_tick;

  // Period counter, restarted by clear or at the end of each period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// serial_rx
// 8N1 asynchronous receiver with 16x oversampling and 3-sample majority
// voting at ticks 7/8/9 of each bit. Emits each byte with a one-cycle
// rcv_valid strobe; a low stop bit gives a one-cycle rcv_frame_err strobe
// and the receiver then waits for the line to go high again.
// OVERSAMPLE must be 16: the sample positions assume a 4-bit sub-bit count.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    serial_rx_if.master (rxd in; rcv_data/valid/frame_err/busy out)
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_rx_if.master  bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rxState_t             r_state;
  rxState_t             w_nextState;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxdS;

  logic [3:0]           r_sub;
  logic [2:0]           r_bitcnt;
  logic                 r_s7;
  logic                 r_s8;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;

  logic                 w_tick;
  logic                 w_maj;
  logic                 w_clear;
  logic                 w_busy;
  logic                 w_shift;
  logic                 w_stopDecide;
  logic                 w_validSet;
  logic                 w_ferrSet;
  logic                 w_bitStart;
  logic                 w_bitNext;

  serial_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxdS = r_sync2;

  // The third vote is the live synchronized sample at tick 9
  assign w_maj = majority3(r_s7, r_s8, w_rxdS);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rxdS) w_nextState = START;
      end
      START: begin
        if (w_tick && r_sub == SAMPLE_HI && w_maj) begin
          w_nextState = IDLE;
        end else if (w_tick && r_sub == BIT_END) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (w_tick && r_sub == BIT_END && r_bitcnt == LAST_BIT) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (w_tick && r_sub == SAMPLE_HI) begin
          w_nextState = w_maj ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (w_rxdS) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_clear      = 1'b0;
    w_busy       = 1'b0;
    w_shift      = 1'b0;
    w_stopDecide = 1'b0;
    w_bitStart   = 1'b0;
    w_bitNext    = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = !w_rxdS;
      end
      START: begin
        w_busy     = 1'b1;
        w_bitStart = w_tick && (r_sub == BIT_END);
      end
      DATA: begin
        w_busy    = 1'b1;
        w_shift   = w_tick && (r_sub == SAMPLE_HI);
        w_bitNext = w_tick && (r_sub == BIT_END);
      end
      STOP: begin
        w_busy       = 1'b1;
        w_stopDecide = w_tick && (r_sub == SAMPLE_HI);
      end
      BREAK: begin
        w_busy = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign w_validSet = w_stopDecide &  w_maj;
  assign w_ferrSet  = w_stopDecide & ~w_maj;

  // Sub-bit counter, vote samples, shift register, bit counter and strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sub    <= '0;
      r_bitcnt <= '0;
      r_s7     <= 1'b0;
      r_s8     <= 1'b0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= w_validSet;
      r_ferr  <= w_ferrSet;

      if (w_clear) begin
        r_sub <= '0;
      end else if (w_tick && w_busy) begin
        r_sub <= r_sub + 4'd1;
      end

      if (w_tick && w_busy && r_sub == SAMPLE_LO)  r_s7 <= w_rxdS;
      if (w_tick && w_busy && r_sub == SAMPLE_MID) r_s8 <= w_rxdS;

      // Shift in at the MSB so the first bit ends up in bit 0
      if (w_shift) r_shreg <= {w_maj, r_shreg[DATA_BITS-1:1]};

      if (w_bitStart) begin
        r_bitcnt <= '0;
      end else if (w_bitNext) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_stopDecide) r_data <= r_shreg;
    end
  end

  assign bus.rcv_data      = r_data;
  assign bus.rcv_valid     = r_valid;
  assign bus.rcv_frame_err = r_ferr;
  assign bus.rcv_busy      = w_busy;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx
// Directed bench for serial_rx at the default 50 MHz / 115200 baud.
// Frames are driven bit by bit from the initial block; a negedge monitor
// counts strobes and collects received bytes.
module tb_serial_rx;

  localparam int PERIOD    = 432;
  localparam int PERIOD_FAST = 424;

  logic clk;
  logic rst_n;

  serial_rx_if bus ();

  serial_rx #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (115200),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int lastValidCyc = 0;
  int validCount = 0;
  int ferrCount = 0;
  int bothCount = 0;
  logic [7:0] rxQ[$];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rcv_valid) begin
        validCount++;
        lastValidCyc = cyc;
        rxQ.push_back(bus.rcv_data);
      end
      if (bus.rcv_frame_err) ferrCount++;
      if (bus.rcv_valid && bus.rcv_frame_err) bothCount++;
    end
  end

  initial begin
    #(200000 * 20);
    $display("[TB] FAIL watchdog timeout observed=expired expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; stopLow>0 holds the stop bit low for that many periods
  // first, glitch inverts one clock of each data bit at receiver tick 8.
  task automatic applyStimulus(input logic [7:0] b, input int period,
                               input int stopLow, input bit glitch);
    bus.rxd  = 1'b0;
    startCyc = cyc;
    waitCycles(period);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      if (glitch) begin
        waitCycles(243);
        bus.rxd = ~b[i];
        waitCycles(1);
        bus.rxd = b[i];
        waitCycles(period - 244);
      end else begin
        waitCycles(period);
      end
    end
    if (stopLow > 0) begin
      bus.rxd = 1'b0;
      waitCycles(stopLow * period);
    end
    bus.rxd = 1'b1;
    waitCycles(period);
  endtask

  int v0;
  int f0;
  int lat;

  initial begin
    bus.rxd = 1'b1;
    rst_n   = 1'b0;
    waitCycles(5);
    rst_n = 1'b1;
    waitCycles(2);

    // Reset state
    checkOutput("reset_data",  {24'd0, bus.rcv_data}, 32'h00);
    checkOutput("reset_valid", {31'd0, bus.rcv_valid}, 32'd0);
    checkOutput("reset_ferr",  {31'd0, bus.rcv_frame_err}, 32'd0);
    checkOutput("reset_busy",  {31'd0, bus.rcv_busy}, 32'd0);

    // Single byte '@'
    $display("[TB] single byte 0x40");
    applyStimulus(8'h40, PERIOD, 0, 1'b0);
    waitCycles(2 * PERIOD);
    checkOutput("single_valid_count", validCount, 1);
    checkOutput("single_data", {24'd0, bus.rcv_data}, 32'h40);
    checkOutput("single_ferr_count", ferrCount, 0);
    checkOutput("single_busy_after", {31'd0, bus.rcv_busy}, 32'd0);
    lat = lastValidCyc - startCyc;
    checkOutput("single_latency_4161pm1", {31'd0, (lat >= 4160 && lat <= 4162)}, 32'd1);

    // Back-to-back "@0/\n"
    $display("[TB] back-to-back frames");
    rxQ.delete();
    v0 = validCount;
    applyStimulus(8'h40, PERIOD, 0, 1'b0);
    applyStimulus(8'h30, PERIOD, 0, 1'b0);
    applyStimulus(8'h2F, PERIOD, 0, 1'b0);
    applyStimulus(8'h0A, PERIOD, 0, 1'b0);
    waitCycles(2 * PERIOD);
    checkOutput("b2b_valid_count", validCount - v0, 4);
    checkOutput("b2b_byte0", (rxQ.size() > 0) ? {24'd0, rxQ[0]} : 32'hFFFF, 32'h40);
    checkOutput("b2b_byte1", (rxQ.size() > 1) ? {24'd0, rxQ[1]} : 32'hFFFF, 32'h30);
    checkOutput("b2b_byte2", (rxQ.size() > 2) ? {24'd0, rxQ[2]} : 32'hFFFF, 32'h2F);
    checkOutput("b2b_byte3", (rxQ.size() > 3) ? {24'd0, rxQ[3]} : 32'hFFFF, 32'h0A);
    checkOutput("b2b_ferr_count", ferrCount, 0);

    // False start: 100-clk low glitch
    $display("[TB] false start");
    v0 = validCount;
    f0 = ferrCount;
    bus.rxd = 1'b0;
    waitCycles(100);
    bus.rxd = 1'b1;
    waitCycles(50);
    checkOutput("false_busy_during", {31'd0, bus.rcv_busy}, 32'd1);
    waitCycles(150);
    checkOutput("false_busy_after", {31'd0, bus.rcv_busy}, 32'd0);
    waitCycles(PERIOD);
    checkOutput("false_no_valid", validCount - v0, 0);
    checkOutput("false_no_ferr", ferrCount - f0, 0);

    // Framing error: 0x55 with the stop bit low for 3 periods
    $display("[TB] framing error");
    v0 = validCount;
    f0 = ferrCount;
    applyStimulus(8'h55, PERIOD, 3, 1'b0);
    waitCycles(PERIOD);
    checkOutput("ferr_count", ferrCount - f0, 1);
    checkOutput("ferr_no_valid", validCount - v0, 0);
    checkOutput("ferr_data", {24'd0, bus.rcv_data}, 32'h55);
    checkOutput("ferr_busy_after", {31'd0, bus.rcv_busy}, 32'd0);
    applyStimulus(8'hA5, PERIOD, 0, 1'b0);
    waitCycles(PERIOD);
    checkOutput("after_ferr_valid", validCount - v0, 1);
    checkOutput("after_ferr_data", {24'd0, bus.rcv_data}, 32'hA5);
    checkOutput("after_ferr_no_new_ferr", ferrCount - f0, 1);

    // Noise glitches and +2% baud
    $display("[TB] noise and baud error");
    v0 = validCount;
    applyStimulus(8'hC3, PERIOD, 0, 1'b1);
    waitCycles(PERIOD);
    checkOutput("noise_valid", validCount - v0, 1);
    checkOutput("noise_data", {24'd0, bus.rcv_data}, 32'hC3);
    applyStimulus(8'h3C, PERIOD_FAST, 0, 1'b0);
    waitCycles(PERIOD);
    checkOutput("fast_valid", validCount - v0, 2);
    checkOutput("fast_data", {24'd0, bus.rcv_data}, 32'h3C);

    // Reset during data bit 4 of 0xFF
    $display("[TB] reset mid-frame");
    v0 = validCount;
    f0 = ferrCount;
    bus.rxd = 1'b0;
    waitCycles(PERIOD);
    bus.rxd = 1'b1;
    waitCycles(4 * PERIOD + PERIOD / 2);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("midrst_data", {24'd0, bus.rcv_data}, 32'h00);
    checkOutput("midrst_busy", {31'd0, bus.rcv_busy}, 32'd0);
    checkOutput("midrst_valid", {31'd0, bus.rcv_valid}, 32'd0);
    checkOutput("midrst_ferr", {31'd0, bus.rcv_frame_err}, 32'd0);
    waitCycles(3000);
    checkOutput("midrst_no_valid", validCount - v0, 0);
    checkOutput("midrst_no_ferr", ferrCount - f0, 0);
    applyStimulus(8'h12, PERIOD, 0, 1'b0);
    waitCycles(PERIOD);
    checkOutput("midrst_next_valid", validCount - v0, 1);
    checkOutput("midrst_next_data", {24'd0, bus.rcv_data}, 32'h12);

    checkOutput("valid_ferr_exclusive", bothCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
